// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, data width, default divider and parity helper.
// Used by both the transmitter and the receiver check.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned DIV_NUM_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  // Byte being serialised plus its parity bit, latched together at pop time.
  typedef struct packed {
    logic                   parity;
    logic [UART_DATA_W-1:0] data;
  } uart_frame_t;

  function automatic logic uart_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Read-side handshake between the TX byte FIFO (master) and the transmitter (slave).
interface uart_tx_frame_if;
  import uart_pkg::*;

  logic                   fifo_empty;
  logic [UART_DATA_W-1:0] txd_from_fifo;
  logic                   r_en;

  modport master (output fifo_empty, output txd_from_fifo, input r_en);
  modport slave  (input fifo_empty, input txd_from_fifo, output r_en);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV_NUM-1 while not cleared, flags the last cycle of each bit.
module uart_baud_tick #(
  parameter  int unsigned DIV_NUM = 16,
  localparam int unsigned CNT_W   = (DIV_NUM > 1) ? $clog2(DIV_NUM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_bit_end_c
);

  assign o_bit_end_c = (o_cnt == CNT_W'(DIV_NUM - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clr || o_bit_end_c) begin
      o_cnt <= '0;
    end else begin
      o_cnt <= o_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: pops one byte from a FWFT FIFO and sends start, 8 data bits LSB first,
// parity and STOP_BITS stop bits, each held for DIV_NUM clk_uart cycles.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DIV_NUM   = DIV_NUM_DEF,
  parameter int unsigned STOP_BITS = 2
) (
  input  logic            clk_uart,
  input  logic            rst,
  uart_tx_frame_if.slave  fifo_if,
  output logic            txd,
  output logic            tx_busy,
  output logic            tx_done
);

  localparam int unsigned CNT_W = (DIV_NUM > 1) ? $clog2(DIV_NUM) : 1;

  uart_state_e      r_state, w_state_nxt;
  uart_frame_t      r_frame, w_frame_nxt;
  logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic             r_txd, w_txd_nxt;
  logic             r_tx_busy;
  logic             r_tx_done, w_tx_done_nxt;
  logic             w_r_en;
  logic [CNT_W-1:0] w_baud_cnt;
  logic             w_bit_end;
  logic             w_last_stop;

  uart_baud_tick #(.DIV_NUM(DIV_NUM)) u_baud (
    .clk         (clk_uart),
    .rst         (rst),
    .i_clr       (r_state == IDLE),
    .o_cnt       (w_baud_cnt),
    .o_bit_end_c (w_bit_end)
  );

  assign w_last_stop   = (r_bit_cnt == 3'(STOP_BITS - 1));
  assign fifo_if.r_en  = w_r_en && !rst;
  assign txd           = r_txd;
  assign tx_busy       = r_tx_busy;
  assign tx_done       = r_tx_done;

  // Next-state, shift register and registered-output precompute.
  always_comb begin
    w_state_nxt   = r_state;
    w_frame_nxt   = r_frame;
    w_bit_cnt_nxt = r_bit_cnt;
    w_r_en        = 1'b0;
    w_txd_nxt     = 1'b1;
    w_tx_done_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (!fifo_if.fifo_empty) begin
          w_r_en             = 1'b1;
          w_frame_nxt.data   = fifo_if.txd_from_fifo;
          w_frame_nxt.parity = uart_parity(fifo_if.txd_from_fifo);
          w_state_nxt        = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt   = DATA;
          w_bit_cnt_nxt = 3'd0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_frame_nxt.data = {1'b1, r_frame.data[UART_DATA_W-1:1]};
          w_bit_cnt_nxt    = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = PARITY;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt   = STOP;
          w_bit_cnt_nxt = 3'd0;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (w_last_stop) begin
            w_state_nxt = IDLE;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // txd is registered, so it follows the state being entered.
    case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_frame_nxt.data[0];
      PARITY:  w_txd_nxt = r_frame.parity;
      default: w_txd_nxt = 1'b1;
    endcase

    // Registered one cycle early so the pulse lands on the final stop-bit cycle.
    w_tx_done_nxt = (r_state == STOP) && w_last_stop &&
                    (w_baud_cnt == CNT_W'(DIV_NUM - 2));
  end

  always_ff @(posedge clk_uart) begin
    if (rst) begin
      r_state   <= IDLE;
      r_frame   <= '1;
      r_bit_cnt <= 3'd0;
      r_txd     <= 1'b1;
      r_tx_busy <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_frame   <= w_frame_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_txd     <= w_txd_nxt;
      r_tx_busy <= (w_state_nxt != IDLE);
      r_tx_done <= w_tx_done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at DIV_NUM=16, STOP_BITS=2 with a queue-backed FWFT FIFO.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd, tx_busy, tx_done;

  uart_tx_frame_if fif ();

  uart_tx_frame #(.DIV_NUM(16), .STOP_BITS(2)) dut (
    .clk_uart (clk),
    .rst      (rst),
    .fifo_if  (fif),
    .txd      (txd),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic s_txd, s_ren, s_busy, s_done;
  int   hi_run = 0;
  int   last_hi = 0;
  int   hi_at_start = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_drive();
    fif.fifo_empty    = (q.size() == 0);
    fif.txd_from_fifo = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // One clock cycle: sample on the falling edge, pop/update FIFO just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    s_txd  = txd;
    s_ren  = fif.r_en;
    s_busy = tx_busy;
    s_done = tx_done;
    if (s_txd === 1'b1) hi_run++;
    else begin
      if (hi_run != 0) last_hi = hi_run;
      hi_run = 0;
    end
    @(posedge clk);
    #1;
    if (s_ren === 1'b1 && q.size() != 0) void'(q.pop_front());
    fifo_drive();
  endtask

  task automatic wait_ren(input int budget, input string tag);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    do begin
      cyc();
      n++;
      if (s_ren === 1'b1) got = 1'b1;
    end while (!got && n < budget);
    chk({tag, "_ren_seen"}, 32'(got), 32'd1);
    chk({tag, "_busy_at_ren"}, 32'(s_busy), 32'd0);
  endtask

  // Call right after the cycle that sampled r_en=1; walks the 192-cycle frame.
  task automatic frame(input logic [7:0] b, input logic par, input string tag);
    logic [11:0] exp_bits;
    logic [7:0]  rx;
    int bad_txd, bad_busy, done_cnt, done_at, ren_cnt;
    exp_bits = {2'b11, par, b, 1'b0};
    rx       = 8'h00;
    bad_txd  = 0;
    bad_busy = 0;
    done_cnt = 0;
    done_at  = 0;
    ren_cnt  = 0;
    for (int c = 1; c <= 192; c++) begin
      int bi;
      int pos;
      cyc();
      bi  = (c - 1) / 16;
      pos = (c - 1) % 16;
      if (c == 1) hi_at_start = last_hi;
      if (s_txd !== exp_bits[bi]) bad_txd++;
      if (s_busy !== 1'b1) bad_busy++;
      if (s_ren === 1'b1) ren_cnt++;
      if (s_done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (pos == 8) begin
        chk($sformatf("%s_bit%0d", tag, bi), 32'(s_txd), 32'(exp_bits[bi]));
        if (bi >= 1 && bi <= 8) rx[bi-1] = s_txd;
      end
    end
    chk({tag, "_txd_every_cycle_bad"}, 32'(bad_txd), 32'd0);
    chk({tag, "_busy_bad"}, 32'(bad_busy), 32'd0);
    chk({tag, "_ren_in_frame"}, 32'(ren_cnt), 32'd0);
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_cycle"}, 32'(done_at), 32'd192);
    chk({tag, "_rx_data"}, 32'(rx), 32'(b));
  endtask

  initial begin
    int bad;
    logic [7:0] lb[3];
    logic       lp[3];
    fifo_drive();

    // Reset values
    repeat (3) cyc();
    chk("rst_txd", 32'(s_txd), 32'd1);
    chk("rst_ren", 32'(s_ren), 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_done", 32'(s_done), 32'd0);
    rst = 1'b0;

    // Idle with empty FIFO
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      cyc();
      if (s_txd !== 1'b1 || s_ren !== 1'b0 || s_busy !== 1'b0 || s_done !== 1'b0) bad++;
    end
    chk("idle_empty_bad", 32'(bad), 32'd0);

    // Single byte 0xA5 (even weight -> parity 0)
    q.push_back(8'hA5);
    fifo_drive();
    wait_ren(10, "a5");
    frame(8'hA5, 1'b0, "a5");
    cyc();
    chk("a5_idle_txd", 32'(s_txd), 32'd1);
    chk("a5_idle_busy", 32'(s_busy), 32'd0);
    chk("a5_idle_ren", 32'(s_ren), 32'd0);

    // Parity corner bytes
    q.push_back(8'h01);
    fifo_drive();
    wait_ren(10, "x01");
    frame(8'h01, 1'b1, "x01");
    q.push_back(8'h00);
    fifo_drive();
    wait_ren(10, "x00");
    frame(8'h00, 1'b0, "x00");

    // Back-to-back frames; FIFO head changes mid-frame
    q.push_back(8'h00);
    q.push_back(8'hFF);
    fifo_drive();
    wait_ren(10, "b2b0");
    frame(8'h00, 1'b0, "b2b0");
    cyc();
    chk("b2b_ren_after_done", 32'(s_ren), 32'd1);
    chk("b2b_idle_txd", 32'(s_txd), 32'd1);
    frame(8'hFF, 1'b0, "b2b1");
    chk("b2b_line_high", 32'(hi_at_start), 32'd33);

    // Reset at cycle 50 of a 0x3C frame, then a fresh frame
    q.push_back(8'h3C);
    q.push_back(8'h3C);
    fifo_drive();
    wait_ren(10, "r3c");
    repeat (50) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_mid_txd", 32'(s_txd), 32'd1);
    chk("rst_mid_busy", 32'(s_busy), 32'd0);
    chk("rst_mid_ren", 32'(s_ren), 32'd1);
    frame(8'h3C, 1'b0, "r3c_new");

    // Loopback-style decode of three bytes
    lb[0] = 8'h55; lp[0] = 1'b0;
    lb[1] = 8'hAA; lp[1] = 1'b0;
    lb[2] = 8'h80; lp[2] = 1'b1;
    for (int k = 0; k < 3; k++) q.push_back(lb[k]);
    fifo_drive();
    for (int k = 0; k < 3; k++) begin
      wait_ren(10, $sformatf("lb%0d", k));
      frame(lb[k], lp[k], $sformatf("lb%0d", k));
    end
    cyc();
    chk("final_busy", 32'(s_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
